// File: rtl/af_pkg.sv
// Shared types for the autofocus sweep controller: FSM state encoding and
// the fine-window clamp helper.
package af_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        C_SETTLE = 3'd1,
        C_SAMPLE = 3'd2,
        F_SETTLE = 3'd3,
        F_SAMPLE = 3'd4,
        PARK     = 3'd5,
        DONE     = 3'd6
    } af_state_t;

    typedef struct packed {
        int lo;
        int hi;
    } af_win_t;

    // Signed 32-bit math so peak-half may go negative and peak+half may pass max_pos without wrapping
    function automatic af_win_t af_window(input int peak, input int half, input int max_pos);
        af_win_t w;
        w.lo = (peak < half) ? 0 : peak - half;
        w.hi = (peak + half > max_pos) ? max_pos : peak + half;
        return w;
    endfunction

endpackage

// File: rtl/af_peak_track.sv
// Running sharpness peak (value and step position). Strictly-greater update,
// so on an ascending sweep ties keep the lower step.
module af_peak_track #(
    parameter int STEP_W  = 11,
    parameter int SHARP_W = 24
) (
    input  logic               CLK,
    input  logic               RESET_n,
    input  logic               clr,
    input  logic [STEP_W-1:0]  clr_pos,
    input  logic               smp,
    input  logic [SHARP_W-1:0] sharp,
    input  logic [STEP_W-1:0]  pos,
    output logic [SHARP_W-1:0] peak_val,
    output logic [STEP_W-1:0]  peak_pos,
    output logic [STEP_W-1:0]  peak_pos_nxt
);

    logic upd;

    assign upd          = smp && (sharp > peak_val);
    assign peak_pos_nxt = upd ? pos : peak_pos;

    // clr wins over a coincident sample; the caller reads peak_pos_nxt that cycle
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            peak_val <= '0;
            peak_pos <= '0;
        end else if (clr) begin
            peak_val <= '0;
            peak_pos <= clr_pos;
        end else if (upd) begin
            peak_val <= sharp;
            peak_pos <= pos;
        end
    end

endmodule

// File: rtl/af_sweep_ctrl.sv
// Autofocus coarse/fine sweep controller driving the VCM DAC step code.
// Optional SHARP_VALID watchdog enabled by defining AF_TIMEOUT_EN.
module af_sweep_ctrl #(
    parameter int STEP_W      = 11,
    parameter int SHARP_W     = 24,
    parameter int COARSE_STEP = 3,
    parameter int FINE_STEP   = 1,
    parameter int STEP_MAX    = 'h3F0,
    parameter int SETTLE_CYC  = 4
`ifdef AF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2**20
`endif
) (
    input  logic               CLK,
    input  logic               RESET_n,
    input  logic               START,
    input  logic               SHARP_VALID,
    input  logic [SHARP_W-1:0] SHARP,
    output logic [STEP_W-1:0]  STEP,
    output logic               V_C,
    output logic               BUSY,
    output logic               VCM_END,
    output logic [STEP_W-1:0]  BEST_STEP,
    output logic [SHARP_W-1:0] BEST_SHARP,
    output logic               ERR
);
    import af_pkg::*;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    af_state_t          state;
    logic [SET_W-1:0]   settle_cnt;
    logic [STEP_W-1:0]  win_hi;
    logic [STEP_W:0]    c_nxt;
    logic [STEP_W:0]    f_nxt;
    logic               c_fits;
    logic               f_fits;
    logic               in_sample;
    logic               accept;
    logic               start_ok;
    logic               coarse_end;
    logic               clr;
    logic [STEP_W-1:0]  clr_pos;
    logic [SHARP_W-1:0] pk_val;
    logic [STEP_W-1:0]  pk_pos;
    logic [STEP_W-1:0]  pk_pos_nxt;
    af_win_t            win;

    assign in_sample = (state == C_SAMPLE) || (state == F_SAMPLE);
    assign start_ok  = START && ((state == IDLE) || (state == DONE));

    // Advance checks one bit wider than STEP so the next position never wraps
    assign c_nxt  = {1'b0, STEP} + (STEP_W+1)'(COARSE_STEP);
    assign f_nxt  = {1'b0, STEP} + (STEP_W+1)'(FINE_STEP);
    assign c_fits = c_nxt <= (STEP_W+1)'(STEP_MAX);
    assign f_fits = f_nxt <= {1'b0, win_hi};

    // Window uses the peak including the sample being accepted this cycle
    assign win        = af_window(int'(pk_pos_nxt), COARSE_STEP, STEP_MAX);
    assign coarse_end = (state == C_SAMPLE) && accept && !c_fits;
    assign clr        = start_ok || coarse_end;
    assign clr_pos    = coarse_end ? STEP_W'(win.lo) : '0;

`ifdef AF_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;

    assign timeout = in_sample && !SHARP_VALID && (wd_cnt == WD_W'(TIMEOUT_CYC-1));
    assign accept  = in_sample && (SHARP_VALID || timeout);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wd_cnt <= '0;
            ERR    <= 1'b0;
        end else begin
            if (!in_sample || accept) wd_cnt <= '0;
            else                      wd_cnt <= wd_cnt + 1'b1;
            if (start_ok)     ERR <= 1'b0;
            else if (timeout) ERR <= 1'b1;
        end
    end
`else
    assign accept = in_sample && SHARP_VALID;
    assign ERR    = 1'b0;
`endif

    af_peak_track #(
        .STEP_W  (STEP_W),
        .SHARP_W (SHARP_W)
    ) u_peak (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .clr          (clr),
        .clr_pos      (clr_pos),
        .smp          (in_sample && SHARP_VALID),
        .sharp        (SHARP),
        .pos          (STEP),
        .peak_val     (pk_val),
        .peak_pos     (pk_pos),
        .peak_pos_nxt (pk_pos_nxt)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            win_hi     <= '0;
            STEP       <= '0;
            V_C        <= 1'b0;
            BUSY       <= 1'b0;
            VCM_END    <= 1'b0;
            BEST_STEP  <= '0;
            BEST_SHARP <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        STEP       <= '0;
                        V_C        <= 1'b0;
                        BUSY       <= 1'b1;
                        VCM_END    <= 1'b0;
                        settle_cnt <= '0;
                        state      <= C_SETTLE;
                    end
                end
                C_SETTLE, F_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC-1)) begin
                        settle_cnt <= '0;
                        state      <= (state == C_SETTLE) ? C_SAMPLE : F_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                C_SAMPLE: begin
                    if (accept) begin
                        if (c_fits) begin
                            STEP  <= c_nxt[STEP_W-1:0];
                            state <= C_SETTLE;
                        end else begin
                            V_C    <= 1'b1;
                            STEP   <= STEP_W'(win.lo);
                            win_hi <= STEP_W'(win.hi);
                            state  <= F_SETTLE;
                        end
                    end
                end
                F_SAMPLE: begin
                    if (accept) begin
                        if (f_fits) begin
                            STEP  <= f_nxt[STEP_W-1:0];
                            state <= F_SETTLE;
                        end else begin
                            state <= PARK;
                        end
                    end
                end
                PARK: begin
                    STEP       <= pk_pos;
                    BEST_STEP  <= pk_pos;
                    BEST_SHARP <= pk_val;
                    BUSY       <= 1'b0;
                    VCM_END    <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
